// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register indices, latch commands and hazard-controller states.
package cpu_types_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned PIPE_W = 2;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [PIPE_W-1:0] {
    PIPE_ENABLE = 2'b00,
    PIPE_STALL  = 2'b01,
    PIPE_NOP    = 2'b10
  } pipe_state_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    HALTING = 2'b01,
    HALTED  = 2'b10
  } hazctrl_state_t;

  // One cycle's worth of commands to the four pipeline latches plus the PC.
  typedef struct packed {
    pipe_state_t fd;
    pipe_state_t de;
    pipe_state_t em;
    pipe_state_t mw;
    logic        pc_en;
  } pipe_cmd_t;

  function automatic pipe_cmd_t mk_cmd(input pipe_state_t fd,
                                       input pipe_state_t de,
                                       input pipe_state_t em,
                                       input pipe_state_t mw,
                                       input logic        pc_en);
    pipe_cmd_t c;
    c.fd    = fd;
    c.de    = de;
    c.em    = em;
    c.mw    = mw;
    c.pc_en = pc_en;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-status inputs and latch-command outputs exchanged between the pipeline and its sequencer.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import cpu_types_pkg::*;

  logic             ihit;
  logic             dhit;
  regbits_t         d_rs;
  regbits_t         d_rt;
  logic             e_dREN;
  regbits_t         e_regWSEL;
  logic             m_dREN;
  logic             m_dWEN;
  logic             m_branch_taken;
  logic             m_halt;

  pipe_state_t      fd_state;
  pipe_state_t      de_state;
  pipe_state_t      em_state;
  pipe_state_t      mw_state;
  logic             pc_en;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Sequencer side.
  modport master (
    input  ihit, dhit, d_rs, d_rt, e_dREN, e_regWSEL,
           m_dREN, m_dWEN, m_branch_taken, m_halt,
    output fd_state, de_state, em_state, mw_state,
           pc_en, halt, stall_cnt, flush_cnt
  );

  // Datapath side.
  modport slave (
    output ihit, dhit, d_rs, d_rt, e_dREN, e_regWSEL,
           m_dREN, m_dWEN, m_branch_taken, m_halt,
    input  fd_state, de_state, em_state, mw_state,
           pc_en, halt, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones instead of wrapping.
module hazard_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch sequencer: resolves memory waits, load-use, MEM-stage redirects and halt drain,
// and keeps debug counters of stall cycles and branch flushes.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  pipeline_hazard_ctrl_if.master bus
);

  localparam int unsigned    DRAIN_W    = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

  hazctrl_state_t     state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               halt_q,  halt_d;

  pipe_cmd_t cmd;
  logic      dwait;
  logic      load_use;
  logic      stall_inc;
  logic      flush_inc;

  assign dwait    = (bus.m_dREN | bus.m_dWEN) & ~bus.dhit;
  assign load_use = bus.e_dREN && (bus.e_regWSEL != '0) &&
                    ((bus.e_regWSEL == bus.d_rs) || (bus.e_regWSEL == bus.d_rt));

  // Next-state and latch-command decode; RUN rules are evaluated in priority order.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    halt_d    = halt_q;
    cmd       = mk_cmd(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1);
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (RST) begin
      cmd = mk_cmd(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0);
    end else begin
      case (state_q)
        RUN: begin
          if (dwait) begin
            // Branch and halt sitting in MEM wait until the data access completes.
            cmd       = mk_cmd(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
            stall_inc = 1'b1;
          end else if (bus.m_halt) begin
            cmd       = mk_cmd(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b0);
            stall_inc = 1'b1;
            state_d   = HALTING;
            drain_d   = DRAIN_INIT;
          end else if (bus.m_branch_taken) begin
            // Flush squashes any younger load, so it wins over load-use.
            cmd       = mk_cmd(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b1);
            flush_inc = 1'b1;
          end else if (load_use) begin
            cmd       = mk_cmd(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
            stall_inc = 1'b1;
          end else if (!bus.ihit) begin
            cmd       = mk_cmd(PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
            stall_inc = 1'b1;
          end
        end

        HALTING: begin
          cmd = mk_cmd(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b0);
          if (drain_q <= DRAIN_W'(1)) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end

        HALTED: begin
          cmd = mk_cmd(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
        end

        default: begin
          cmd     = mk_cmd(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0);
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      drain_q <= DRAIN_INIT;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      halt_q  <= halt_d;
    end
  end

  hazard_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .clr (RST),
    .inc (stall_inc),
    .cnt (bus.stall_cnt)
  );

  hazard_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK (CLK),
    .clr (RST),
    .inc (flush_inc),
    .cnt (bus.flush_cnt)
  );

  assign bus.fd_state = cmd.fd;
  assign bus.de_state = cmd.de;
  assign bus.em_state = cmd.em;
  assign bus.mw_state = cmd.mw;
  assign bus.pc_en    = cmd.pc_en;
  assign bus.halt     = halt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DRAIN = 1;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  // Reference model: mode 0 = running, 1 = draining, 2 = stopped.
  int mdl_mode;
  int mdl_drain;
  bit mdl_halt;
  int mdl_stalls;
  int mdl_flushes;
  bit mdl_known;

  logic [1:0] e_fd, e_de, e_em, e_mw;
  bit         e_pc, e_stall_ev, e_flush_ev, e_enter_halt;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_cmd(input pipe_state_t fd, input pipe_state_t de,
                         input pipe_state_t em, input pipe_state_t mw, input bit pc);
    e_fd = fd; e_de = de; e_em = em; e_mw = mw; e_pc = pc;
  endtask

  task automatic predict();
    bit data_wait, hazard;
    e_stall_ev = 0; e_flush_ev = 0; e_enter_halt = 0;
    if (RST) begin
      set_cmd(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 0);
    end else if (mdl_mode == 2) begin
      set_cmd(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 0);
    end else if (mdl_mode == 1) begin
      set_cmd(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 0);
    end else begin
      data_wait = (bus.m_dREN || bus.m_dWEN) && !bus.dhit;
      hazard    = bus.e_dREN && (int'(bus.e_regWSEL) != 0) &&
                  (bus.e_regWSEL == bus.d_rs || bus.e_regWSEL == bus.d_rt);
      if (data_wait)               set_cmd(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 0);
      else if (bus.m_halt) begin   set_cmd(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 0); e_enter_halt = 1; end
      else if (bus.m_branch_taken) begin set_cmd(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1); e_flush_ev = 1; end
      else if (hazard)             set_cmd(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 0);
      else if (!bus.ihit)          set_cmd(PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 0);
      else                         set_cmd(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1);
      e_stall_ev = !e_pc;
    end
  endtask

  task automatic advance();
    if (RST) begin
      mdl_mode = 0; mdl_halt = 0; mdl_stalls = 0; mdl_flushes = 0;
      mdl_drain = DRAIN; mdl_known = 1;
    end else if (mdl_mode == 0) begin
      if (e_stall_ev && mdl_stalls < CMAX)  mdl_stalls++;
      if (e_flush_ev && mdl_flushes < CMAX) mdl_flushes++;
      if (e_enter_halt) begin mdl_mode = 1; mdl_drain = DRAIN; end
    end else if (mdl_mode == 1) begin
      if (mdl_drain <= 1) begin mdl_mode = 2; mdl_halt = 1; end
      else mdl_drain--;
    end
  endtask

  // One clock: check outputs mid-cycle, then step the model on the edge.
  task automatic cycle();
    @(negedge CLK);
    predict();
    check("fd_state", 32'(bus.fd_state), 32'(e_fd));
    check("de_state", 32'(bus.de_state), 32'(e_de));
    check("em_state", 32'(bus.em_state), 32'(e_em));
    check("mw_state", 32'(bus.mw_state), 32'(e_mw));
    check("pc_en",    32'(bus.pc_en),    32'(e_pc));
    if (mdl_known) begin
      check("halt",      32'(bus.halt),      32'(mdl_halt));
      check("stall_cnt", 32'(bus.stall_cnt), 32'(mdl_stalls));
      check("flush_cnt", 32'(bus.flush_cnt), 32'(mdl_flushes));
    end
    @(posedge CLK);
    advance();
    #1;
  endtask

  task automatic idle();
    bus.ihit = 1; bus.dhit = 1; bus.d_rs = '0; bus.d_rt = '0;
    bus.e_dREN = 0; bus.e_regWSEL = '0; bus.m_dREN = 0; bus.m_dWEN = 0;
    bus.m_branch_taken = 0; bus.m_halt = 0;
  endtask

  initial begin
    mdl_known = 0; mdl_mode = 0; mdl_drain = DRAIN; mdl_halt = 0;
    mdl_stalls = 0; mdl_flushes = 0;
    RST = 1; idle();
    cycle();
    RST = 0;
    cycle();

    // Load-use on rs, then the same with destination r0.
    bus.e_dREN = 1; bus.e_regWSEL = 5'd5; bus.d_rs = 5'd5;
    cycle();
    bus.e_regWSEL = 5'd0;
    cycle();
    idle();

    // Data-memory wait holding a taken branch, then release.
    bus.m_dREN = 1; bus.dhit = 0; bus.m_branch_taken = 1;
    repeat (3) cycle();
    bus.dhit = 1;
    cycle();
    check("flush_after_dwait", 32'(bus.flush_cnt), 32'd1);
    idle();

    // Branch and load-use in the same cycle.
    bus.m_branch_taken = 1; bus.e_dREN = 1; bus.e_regWSEL = 5'd5; bus.d_rt = 5'd5;
    cycle();
    idle();

    // Halt, drain, then stay halted while inputs move.
    bus.m_halt = 1;
    cycle();
    bus.m_halt = 0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      bus.ihit = i[0];
      bus.m_branch_taken = ~i[0];
      cycle();
    end
    check("halted_flag", 32'(bus.halt), 32'd1);
    idle();

    // Reset out of HALTED.
    RST = 1;
    cycle();
    RST = 0;
    cycle();

    // Counter saturation.
    bus.ihit = 0;
    repeat (20) cycle();
    check("stall_sat", 32'(bus.stall_cnt), 32'(CMAX));
    idle();

    // Randomized traffic with occasional reset to leave HALTED.
    for (int i = 0; i < 800; i++) begin
      RST                = ($urandom_range(0, 99) < 2);
      bus.ihit           = ($urandom_range(0, 9) < 7);
      bus.dhit           = $urandom_range(0, 1) == 1;
      bus.d_rs           = regbits_t'($urandom_range(0, 3));
      bus.d_rt           = regbits_t'($urandom_range(0, 3));
      bus.e_dREN         = $urandom_range(0, 1) == 1;
      bus.e_regWSEL      = regbits_t'($urandom_range(0, 3));
      bus.m_dREN         = ($urandom_range(0, 3) == 0);
      bus.m_dWEN         = ($urandom_range(0, 3) == 0);
      bus.m_branch_taken = ($urandom_range(0, 4) == 0);
      bus.m_halt         = ($urandom_range(0, 99) < 3);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
